// File: rtl/tp_ram_be.sv
// tp_ram_be: two-port (one write, one read) RAM with per-lane byte enables,
// configurable read latency and a hardware clear sequencer.
// After reset is released, or when clr is pulsed, the array is swept to zero
// one word per cycle. While that sweep runs, init_busy is high and all
// accesses are ignored.
// A read that hits the word being written in the same cycle returns
// write-first data.
// Optional feature: define TP_RAM_BE_PARITY_EN to store one even-parity bit
// per lane and to flag mismatches on read through parity_err.

`timescale 1ns/1ps

module tp_ram_be #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int RD_LAT = 2,
    localparam int NLANES = DATA_W / LANE_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wren,
    input  logic [NLANES-1:0] be,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] data,
    input  logic              par_inj,
    input  logic              rden,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              init_busy,
    output logic              parity_err
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic              start_pending;
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic              collide;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] rd_merged;
    logic              rd_perr;

    logic [DATA_W-1:0] pipe_q [RD_LAT];
    logic              pipe_v [RD_LAT];
    logic              pipe_e [RD_LAT];

    assign busy      = (state == CLEAR);
    assign init_busy = busy;

    // Clear sequencer.
    // start_pending arms a sweep for the first edge after reset release.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            start_pending <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pending || clr) begin
                        state         <= CLEAR;
                        clr_cnt       <= '0;
                        start_pending <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Access qualification, the byte-lane mask and the write-first read word.
    always_comb begin
        lane_mask = '0;
        for (int l = 0; l < NLANES; l++) begin
            lane_mask[l*LANE_W +: LANE_W] = {LANE_W{be[l]}};
        end
        wr_in_range = ({1'b0, wr_address} < DEPTH_EXT);
        rd_in_range = ({1'b0, rd_address} < DEPTH_EXT);
        wr_ok       = wren && !busy && wr_in_range;
        rd_ok       = rden && !busy;
        collide     = wr_ok && (wr_address == rd_address);
        rd_raw      = '0;
        if (rd_in_range) begin
            rd_raw = mem[rd_address];
        end
        rd_merged = collide ? ((rd_raw & ~lane_mask) | (data & lane_mask)) : rd_raw;
    end

    // Array write port.
    // The clear sweep has priority; otherwise only enabled lanes are written.
    always_ff @(posedge clock) begin
        if (busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            for (int l = 0; l < NLANES; l++) begin
                if (be[l]) begin
                    mem[wr_address][l*LANE_W +: LANE_W] <= data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

`ifdef TP_RAM_BE_PARITY_EN
    logic [NLANES-1:0] par_mem [DEPTH];
    logic [NLANES-1:0] wr_par;
    logic [NLANES-1:0] rd_par_raw;
    logic [NLANES-1:0] rd_par_merged;

    // Parity generation (lane 0 optionally corrupted) and the read-side check.
    always_comb begin
        wr_par     = '0;
        rd_par_raw = '0;
        rd_perr    = 1'b0;
        for (int l = 0; l < NLANES; l++) begin
            wr_par[l] = ^data[l*LANE_W +: LANE_W];
        end
        wr_par[0] = wr_par[0] ^ par_inj;
        if (rd_in_range) begin
            rd_par_raw = par_mem[rd_address];
        end
        rd_par_merged = collide ? ((rd_par_raw & ~be) | (wr_par & be)) : rd_par_raw;
        for (int l = 0; l < NLANES; l++) begin
            if ((^rd_merged[l*LANE_W +: LANE_W]) != rd_par_merged[l]) begin
                rd_perr = 1'b1;
            end
        end
    end

    // Parity array write port. It mirrors the data array lane by lane.
    always_ff @(posedge clock) begin
        if (busy) begin
            par_mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            for (int l = 0; l < NLANES; l++) begin
                if (be[l]) begin
                    par_mem[wr_address][l] <= wr_par[l];
                end
            end
        end
    end
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign rd_perr        = 1'b0;
`endif

    // Read pipeline of RD_LAT stages.
    // Idle slots carry zero so q and parity_err stay 0 whenever q_valid is 0.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
                pipe_v[i] <= 1'b0;
                pipe_e[i] <= 1'b0;
            end
        end else begin
            pipe_v[0] <= rd_ok;
            pipe_q[0] <= rd_ok ? rd_merged : '0;
            pipe_e[0] <= rd_ok && rd_perr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
        end
    end

    assign q          = pipe_q[RD_LAT-1];
    assign q_valid    = pipe_v[RD_LAT-1];
    assign parity_err = pipe_e[RD_LAT-1];

endmodule

// File: tb/tb_tp_ram_be.sv
// Testbench for tp_ram_be.
// A behavioural model (word array, per-lane parity array, busy countdown and
// a queue of pending read results) predicts every output cycle by cycle.
// Scenario tasks also check the fixed example values from the datasheet.
// Build with TP_RAM_BE_PARITY_EN defined to exercise the parity feature.

`timescale 1ns/1ps

module tb_tp_ram_be;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int LANE_W = 8;
    localparam int DEPTH  = 200;
    localparam int RD_LAT = 2;
    localparam int NL     = DATA_W / LANE_W;
`ifdef TP_RAM_BE_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              wren = 1'b0;
    logic [NL-1:0]     be = '0;
    logic [ADDR_W-1:0] wr_address = '0;
    logic [DATA_W-1:0] data = '0;
    logic              par_inj = 1'b0;
    logic              rden = 1'b0;
    logic [ADDR_W-1:0] rd_address = '0;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic              init_busy;
    logic              parity_err;

    tp_ram_be #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clock(clock), .rst_n(rst_n), .clr(clr), .wren(wren), .be(be),
        .wr_address(wr_address), .data(data), .par_inj(par_inj), .rden(rden),
        .rd_address(rd_address), .q(q), .q_valid(q_valid), .init_busy(init_busy),
        .parity_err(parity_err)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit        clr;
        bit        wren;
        bit [1:0]  be;
        int        waddr;
        bit [15:0] wdata;
        bit        inj;
        bit        rden;
        int        raddr;
    } op_t;

    typedef struct {
        int          due;
        logic [15:0] d;
        bit          e;
    } res_t;

    logic [15:0] m_mem [256];
    logic [1:0]  m_par [256];
    res_t        pend [$];
    int          now = 0;
    int          busy_left = 0;
    bit          start_pending = 1'b1;
    logic [15:0] exp_q;
    bit          exp_valid;
    bit          exp_err;
    bit          exp_busy;

    function automatic op_t mk(bit c, bit w, bit [1:0] b, int wa, bit [15:0] wd,
                               bit inj, bit r, int ra);
        op_t o;
        o.clr = c; o.wren = w; o.be = b; o.waddr = wa; o.wdata = wd;
        o.inj = inj; o.rden = r; o.raddr = ra;
        return o;
    endfunction

    function automatic op_t nop();
        return mk(1'b0, 1'b0, 2'b00, 0, 16'h0, 1'b0, 1'b0, 0);
    endfunction

    function automatic op_t wr(int a, bit [15:0] d, bit [1:0] b, bit inj);
        return mk(1'b0, 1'b1, b, a, d, inj, 1'b0, 0);
    endfunction

    function automatic op_t rd(int a);
        return mk(1'b0, 1'b0, 2'b00, 0, 16'h0, 1'b0, 1'b1, a);
    endfunction

    // Lane-wise update of a stored word and its even-parity bits.
    function automatic void merge(input logic [15:0] ow, input logic [1:0] opar,
                                  input logic [15:0] d, input bit [1:0] b, input bit inj,
                                  output logic [15:0] nw, output logic [1:0] np);
        nw = ow;
        np = opar;
        for (int l = 0; l < NL; l++) begin
            if (b[l]) begin
                nw[l*LANE_W +: LANE_W] = d[l*LANE_W +: LANE_W];
                np[l] = (^d[l*LANE_W +: LANE_W]) ^ ((l == 0) && inj);
            end
        end
    endfunction

    function automatic bit parity_bad(logic [15:0] w, logic [1:0] p);
        bit bad = 1'b0;
        for (int l = 0; l < NL; l++) begin
            if ((^w[l*LANE_W +: LANE_W]) !== p[l]) bad = 1'b1;
        end
        return bad && PAR_ON;
    endfunction

    // Drive one cycle, advance the model at the edge, then settle on the falling edge.
    task automatic step(input op_t o);
        res_t        r;
        logic [15:0] w;
        logic [1:0]  p;
        clr        = o.clr;
        wren       = o.wren;
        be         = o.be;
        wr_address = ADDR_W'(o.waddr);
        data       = o.wdata;
        par_inj    = o.inj;
        rden       = o.rden;
        rd_address = ADDR_W'(o.raddr);
        @(posedge clock);
        now++;
        if (busy_left == 0) begin
            if (o.rden) begin
                r.due = now + RD_LAT - 1;
                if (o.raddr >= DEPTH) begin
                    r.d = 16'h0;
                    r.e = 1'b0;
                end else begin
                    w = m_mem[o.raddr];
                    p = m_par[o.raddr];
                    if (o.wren && o.waddr == o.raddr) merge(w, p, o.wdata, o.be, o.inj, w, p);
                    r.d = w;
                    r.e = parity_bad(w, p);
                end
                pend.push_back(r);
            end
            if (o.wren && o.waddr < DEPTH) begin
                merge(m_mem[o.waddr], m_par[o.waddr], o.wdata, o.be, o.inj, w, p);
                m_mem[o.waddr] = w;
                m_par[o.waddr] = p;
            end
            if (start_pending || o.clr) begin
                busy_left     = DEPTH;
                start_pending = 1'b0;
                for (int i = 0; i < 256; i++) begin
                    m_mem[i] = 16'h0;
                    m_par[i] = 2'b00;
                end
            end
        end else begin
            busy_left--;
        end
        exp_busy  = (busy_left > 0);
        exp_valid = 1'b0;
        exp_q     = 16'h0;
        exp_err   = 1'b0;
        if (pend.size() > 0 && pend[0].due == now) begin
            exp_valid = 1'b1;
            exp_q     = pend[0].d;
            exp_err   = pend[0].e;
            void'(pend.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic model_reset();
        pend.delete();
        busy_left     = 0;
        start_pending = 1'b1;
    endtask

    task automatic test_reset();
        int busy_cycles;
        op_t ops [$];
        model_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({q_valid, q, parity_err, init_busy} !== 19'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b q=%h err=%b busy=%b, expected all 0",
                     q_valid, q, parity_err, init_busy);
        end
        rst_n = 1'b1;
        step(nop());
        busy_cycles = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            if (init_busy !== 1'b1) break;
            busy_cycles++;
            step(nop());
            checks++;
            if (init_busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL reset_busy[%0d]: got %b expected %b", i, init_busy, exp_busy);
            end
        end
        checks++;
        if (busy_cycles != DEPTH) begin
            failures++;
            $display("[TB] FAIL reset_clear_len: got %0d cycles expected %0d", busy_cycles, DEPTH);
        end
        ops.push_back(rd(0));
        ops.push_back(rd(DEPTH / 2));
        ops.push_back(rd(DEPTH - 1));
        ops.push_back(nop());
        ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if ({init_busy, q_valid, q, parity_err} !== {exp_busy, exp_valid, exp_q, exp_err}) begin
                failures++;
                $display("[TB] FAIL reset_read_model[%0d]: got b/v/q/e %b/%b/%h/%b expected %b/%b/%h/%b",
                         i, init_busy, q_valid, q, parity_err, exp_busy, exp_valid, exp_q, exp_err);
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (q_valid !== 1'b1 || q !== 16'h0) begin
                    failures++;
                    $display("[TB] FAIL reset_read_zero[%0d]: got valid=%b q=%h expected 1/0000",
                             i, q_valid, q);
                end
            end
        end
    endtask

    task automatic test_latency();
        op_t ops [$];
        ops.push_back(wr(16'h10, 16'hA55A, 2'b11, 1'b0));
        ops.push_back(rd(16'h10));
        ops.push_back(nop());
        ops.push_back(nop());
        ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if ({init_busy, q_valid, q, parity_err} !== {exp_busy, exp_valid, exp_q, exp_err}) begin
                failures++;
                $display("[TB] FAIL latency_model[%0d]: got b/v/q/e %b/%b/%h/%b expected %b/%b/%h/%b",
                         i, init_busy, q_valid, q, parity_err, exp_busy, exp_valid, exp_q, exp_err);
            end
            if (i == 2) begin
                checks++;
                if (q_valid !== 1'b1 || q !== 16'hA55A) begin
                    failures++;
                    $display("[TB] FAIL latency_hit: got valid=%b q=%h expected 1/a55a", q_valid, q);
                end
            end else if (i == 1 || i == 3) begin
                checks++;
                if (q_valid !== 1'b0 || q !== 16'h0) begin
                    failures++;
                    $display("[TB] FAIL latency_off[%0d]: got valid=%b q=%h expected 0/0000",
                             i, q_valid, q);
                end
            end
        end
    endtask

    task automatic test_write_first();
        op_t ops [$];
        ops.push_back(wr(16'h20, 16'h1234, 2'b11, 1'b0));
        ops.push_back(mk(1'b0, 1'b1, 2'b01, 16'h20, 16'hFFEE, 1'b0, 1'b1, 16'h20));
        ops.push_back(wr(16'h20, 16'hBEEF, 2'b00, 1'b0));
        ops.push_back(rd(16'h20));
        ops.push_back(wr(16'h20, 16'h0000, 2'b11, 1'b0));
        ops.push_back(rd(16'h20));
        ops.push_back(nop());
        ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if ({init_busy, q_valid, q, parity_err} !== {exp_busy, exp_valid, exp_q, exp_err}) begin
                failures++;
                $display("[TB] FAIL wfirst_model[%0d]: got b/v/q/e %b/%b/%h/%b expected %b/%b/%h/%b",
                         i, init_busy, q_valid, q, parity_err, exp_busy, exp_valid, exp_q, exp_err);
            end
            if (i == 2 || i == 4) begin
                checks++;
                if (q_valid !== 1'b1 || q !== 16'h12EE) begin
                    failures++;
                    $display("[TB] FAIL wfirst_value[%0d]: got valid=%b q=%h expected 1/12ee",
                             i, q_valid, q);
                end
            end else if (i == 6) begin
                checks++;
                if (q_valid !== 1'b1 || q !== 16'h0000) begin
                    failures++;
                    $display("[TB] FAIL wfirst_later_write: got valid=%b q=%h expected 1/0000",
                             q_valid, q);
                end
            end
        end
    endtask

    task automatic test_parity();
        op_t ops [$];
        ops.push_back(wr(3, 16'h00FF, 2'b11, 1'b1));
        ops.push_back(rd(3));
        ops.push_back(nop());
        ops.push_back(wr(3, 16'h00FF, 2'b11, 1'b0));
        ops.push_back(rd(3));
        ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if ({init_busy, q_valid, q, parity_err} !== {exp_busy, exp_valid, exp_q, exp_err}) begin
                failures++;
                $display("[TB] FAIL parity_model[%0d]: got b/v/q/e %b/%b/%h/%b expected %b/%b/%h/%b",
                         i, init_busy, q_valid, q, parity_err, exp_busy, exp_valid, exp_q, exp_err);
            end
            if (i == 2 || i == 5) begin
                checks++;
                if (q_valid !== 1'b1 || q !== 16'h00FF || parity_err !== ((i == 2) && PAR_ON)) begin
                    failures++;
                    $display("[TB] FAIL parity_value[%0d]: got valid=%b q=%h err=%b expected 1/00ff/%b",
                             i, q_valid, q, parity_err, (i == 2) && PAR_ON);
                end
            end
        end
    endtask

    task automatic test_random();
        op_t o;
        for (int i = 0; i < 400; i++) begin
            o = nop();
            o.wren  = ($urandom_range(0, 1) == 1);
            o.rden  = ($urandom_range(0, 9) < 6);
            o.be    = 2'($urandom);
            o.wdata = 16'($urandom);
            o.inj   = ($urandom_range(0, 7) == 0);
            o.waddr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 255))
                                                   : int'($urandom_range(0, 7));
            o.raddr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 255))
                                                   : int'($urandom_range(0, 7));
            step(o);
            checks++;
            if ({init_busy, q_valid, q, parity_err} !== {exp_busy, exp_valid, exp_q, exp_err}) begin
                failures++;
                $display("[TB] FAIL random[%0d]: got b/v/q/e %b/%b/%h/%b expected %b/%b/%h/%b",
                         i, init_busy, q_valid, q, parity_err, exp_busy, exp_valid, exp_q, exp_err);
            end
        end
        repeat (RD_LAT) step(nop());
    endtask

    task automatic test_clear();
        int  busy_cycles;
        op_t o;
        op_t ops [$];
        step(wr(7, 16'h5555, 2'b11, 1'b0));
        step(wr(150, 16'h7777, 2'b11, 1'b0));
        step(mk(1'b1, 1'b0, 2'b00, 0, 16'h0, 1'b0, 1'b0, 0));
        busy_cycles = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            if (init_busy !== 1'b1) break;
            busy_cycles++;
            o = (i == 160) ? mk(1'b1, 1'b1, 2'b11, 150, 16'hFFFF, 1'b0, 1'b1, 150) : nop();
            step(o);
            checks++;
            if ({init_busy, q_valid, q, parity_err} !== {exp_busy, exp_valid, exp_q, exp_err}) begin
                failures++;
                $display("[TB] FAIL clear_model[%0d]: got b/v/q/e %b/%b/%h/%b expected %b/%b/%h/%b",
                         i, init_busy, q_valid, q, parity_err, exp_busy, exp_valid, exp_q, exp_err);
            end
        end
        checks++;
        if (busy_cycles != DEPTH) begin
            failures++;
            $display("[TB] FAIL clear_len: got %0d cycles expected %0d", busy_cycles, DEPTH);
        end
        ops.push_back(rd(7));
        ops.push_back(rd(150));
        ops.push_back(nop());
        ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if ({init_busy, q_valid, q, parity_err} !== {exp_busy, exp_valid, exp_q, exp_err}) begin
                failures++;
                $display("[TB] FAIL clear_read_model[%0d]: got b/v/q/e %b/%b/%h/%b expected %b/%b/%h/%b",
                         i, init_busy, q_valid, q, parity_err, exp_busy, exp_valid, exp_q, exp_err);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (q_valid !== 1'b1 || q !== 16'h0) begin
                    failures++;
                    $display("[TB] FAIL clear_read_zero[%0d]: got valid=%b q=%h expected 1/0000",
                             i, q_valid, q);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_cycles;
        step(mk(1'b1, 1'b0, 2'b00, 0, 16'h0, 1'b0, 1'b0, 0));
        repeat (100) step(nop());
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({q_valid, q, parity_err, init_busy} !== 19'h0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got valid=%b q=%h err=%b busy=%b, expected all 0",
                     q_valid, q, parity_err, init_busy);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (init_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_hold: got busy=%b expected 0", init_busy);
        end
        rst_n = 1'b1;
        step(nop());
        busy_cycles = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            if (init_busy !== 1'b1) break;
            busy_cycles++;
            step(nop());
        end
        checks++;
        if (busy_cycles != DEPTH) begin
            failures++;
            $display("[TB] FAIL midreset_clear_len: got %0d cycles expected %0d", busy_cycles, DEPTH);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_latency();
        test_write_first();
        test_parity();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tp_ram_be.md
TP_RAM_BE -- requirements
Module: tp_ram_be

Interface
REQ-001 Parameter ADDR_W, default 13, address width in bits.
REQ-002 Parameter DATA_W, default 16, data width in bits; SHALL be an integer multiple of LANE_W.
REQ-003 Parameter LANE_W, default 8, byte-enable lane width; NLANES = DATA_W/LANE_W.
REQ-004 Parameter DEPTH, default 1<<ADDR_W, number of words.
REQ-005 Parameter RD_LAT, default 2, read latency in cycles; legal range 1..4.
REQ-006 clock  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 clr  in  1  single-cycle pulse; requests a full-array clear.
REQ-009 wren  in  1  write enable.
REQ-010 be  in  NLANES  per-lane write enable; bit i covers data[i*LANE_W +: LANE_W].
REQ-011 wr_address  in  ADDR_W  write address.
REQ-012 data  in  DATA_W  write data.
REQ-013 par_inj  in  1  parity-fault injection (lane 0 stored parity inverted on the write).
REQ-014 rden  in  1  read enable.
REQ-015 rd_address  in  ADDR_W  read address.
REQ-016 q  out  DATA_W  read data.
REQ-017 q_valid  out  1  q carries a read result this cycle.
REQ-018 init_busy  out  1  clear in progress; accesses ignored.
REQ-019 parity_err  out  1  parity mismatch on the current q_valid word.

Function
REQ-020 Clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on reset release or on clr in IDLE; CLEAR->IDLE the cycle after address DEPTH-1 is written.
REQ-021 In CLEAR, one word per cycle SHALL be written with all-zero data and all-zero parity, counter 0..DEPTH-1; init_busy=1 throughout CLEAR.
REQ-022 clr while in CLEAR SHALL be ignored (no counter restart).
REQ-023 wren and rden SHALL be ignored while init_busy=1; such reads produce no q_valid.
REQ-024 A write SHALL update only lanes with be[i]=1; be=0 leaves the word unchanged.
REQ-025 A read issued at cycle N SHALL present q and q_valid=1 at cycle N+RD_LAT for exactly one cycle; back-to-back reads SHALL stream one result per cycle.
REQ-026 When q_valid=0, q and parity_err SHALL be 0.
REQ-027 Same-cycle wren and rden to the same address SHALL return write-first data: enabled lanes from data, disabled lanes from stored content.
REQ-028 Writes issued after the read cycle SHALL NOT affect that read's result.
REQ-029 Addresses >= DEPTH (non-power-of-two DEPTH) SHALL be dropped on write and return 0 with q_valid=1 on read.

Reset
REQ-030 While rst_n=0: q=0, q_valid=0, parity_err=0, init_busy=0, FSM=IDLE, counter=0, read pipeline flushed.
REQ-031 First rising edge after rst_n release SHALL enter CLEAR; reset asserted mid-CLEAR aborts it and the clear restarts from address 0 on release.
REQ-032 Array contents are not reset directly; the post-reset clear provides zero initialisation.

Configuration
REQ-033 Macro TP_RAM_BE_PARITY_EN defined: one even-parity bit per lane stored with each write (updated only for enabled lanes), recomputed on read; parity_err=1 with q_valid if any lane mismatches; par_inj=1 stores inverted lane-0 parity.
REQ-034 Macro undefined: no parity storage, parity_err tied 0, par_inj ignored.

Verification
REQ-035 Reset release -> init_busy=1 for DEPTH cycles, then 0; reads of addresses 0, DEPTH/2 and DEPTH-1 return 0.
REQ-036 RD_LAT=2: write 0xA55A at 0x10, rden at 0x10 at cycle N -> q=0xA55A, q_valid=1 at N+2 only.
REQ-037 Stored 0x1234 at 0x20; same-cycle wren be=2'b01 data=0xFFEE and rden at 0x20 -> q=0x12EE.
REQ-038 clr pulse after 0x5555 written at 0x7 -> init_busy=1 for DEPTH cycles; a wren during the clear is dropped; read of 0x7 afterwards returns 0.
REQ-039 PARITY_EN: write 0x00FF with par_inj=1 at 0x3, read 0x3 -> q=0x00FF, parity_err=1; rewrite with par_inj=0 -> parity_err=0.
REQ-040 rst_n pulsed low at counter=100 during CLEAR -> outputs zero immediately; on release the clear restarts at 0 and runs the full DEPTH cycles.
